// File: rtl/line_buffer_3row.sv
// Vertical 3-row line buffer: emits rows r-2, r-1, r per accepted raster word.
// Define LINE_BUFFER_ZERO_PAD_EN for same-padding mode (zero rows above/below, flush row).
module line_buffer_3row #(
   parameter int WIDTH     = 64,
   parameter int MAX_DEPTH = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [9:0]       img_width,
   input  logic [9:0]       img_height,
   input  logic [7:0]       cin_groups,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_tap0,
   output logic [WIDTH-1:0] m_tap1,
   output logic [WIDTH-1:0] m_tap2,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy,
   output logic             done
);
   localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   state_t           r_state;
   logic [17:0]      r_row_len;
   logic [17:0]      r_ptr;
   logic [9:0]       r_height;
   logic [9:0]       r_row;
   logic             r_in_done;
   logic             r_valid;
   logic             r_last;
   logic             r_done;
   logic             r_en0;
   logic             r_en1;
   logic             r_en2;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_rd_old;
   logic [WIDTH-1:0] r_rd_new;
   logic [WIDTH-1:0] r_buf_old [MAX_DEPTH];
   logic [WIDTH-1:0] r_buf_new [MAX_DEPTH];

   logic          w_out_free;
   logic          w_s_ready;
   logic          w_accept;
   logic          w_flush_step;
   logic          w_step;
   logic          w_emit;
   logic          w_emit_last;
   logic          w_ptr_wrap;
   logic          w_last_row;
   logic          w_hs_last;
   logic          w_cfg_zero;
   logic [AW-1:0] w_addr;

   assign w_out_free   = !r_valid || m_ready;
   assign w_s_ready    = ((r_state == S_FILL) || (r_state == S_RUN)) && !r_in_done && w_out_free;
   assign w_accept     = s_valid && w_s_ready;
   assign w_flush_step = (r_state == S_FLUSH) && !r_in_done && w_out_free;
   assign w_step       = w_accept || w_flush_step;
   assign w_addr       = r_ptr[AW-1:0];
   assign w_ptr_wrap   = (r_ptr == r_row_len - 18'd1);
   assign w_last_row   = (r_row == r_height - 10'd1);
   assign w_hs_last    = r_valid && m_ready && r_last;
   assign w_cfg_zero   = (img_width == 10'd0) || (img_height == 10'd0) || (cin_groups == 8'd0);

`ifdef LINE_BUFFER_ZERO_PAD_EN
   assign w_emit      = w_accept || w_flush_step;
   assign w_emit_last = w_flush_step && w_ptr_wrap;
`else
   assign w_emit      = w_accept && (r_state == S_RUN);
   assign w_emit_last = w_emit && w_last_row && w_ptr_wrap;
`endif

   // Read-first RAM pair: the pre-write row contents become taps 0/1 one cycle later.
   always_ff @(posedge clk) begin
      if (w_step) begin
         r_rd_old <= r_buf_old[w_addr];
         r_rd_new <= r_buf_new[w_addr];
      end
      if (w_accept) begin
         r_buf_old[w_addr] <= r_buf_new[w_addr];
         r_buf_new[w_addr] <= s_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_row_len <= '0;
         r_ptr     <= '0;
         r_height  <= '0;
         r_row     <= '0;
         r_in_done <= 1'b0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_en0     <= 1'b0;
         r_en1     <= 1'b0;
         r_en2     <= 1'b0;
         r_data    <= '0;
      end else begin
         r_done <= 1'b0;

         if (w_out_free) begin
            r_valid <= w_emit;
            r_last  <= w_emit_last;
         end

         if (w_emit) begin
            r_data <= s_data;
`ifdef LINE_BUFFER_ZERO_PAD_EN
            // Rows above the image and the row below it read as zero.
            r_en0 <= (r_state == S_FLUSH) ? (r_height >= 10'd2) : (r_row >= 10'd2);
            r_en1 <= (r_state == S_FLUSH) ? 1'b1 : (r_row >= 10'd1);
            r_en2 <= (r_state != S_FLUSH);
`else
            r_en0 <= 1'b1;
            r_en1 <= 1'b1;
            r_en2 <= 1'b1;
`endif
         end

         if (w_step) begin
            if (w_ptr_wrap) begin
               r_ptr <= '0;
               r_row <= r_row + 10'd1;
            end else begin
               r_ptr <= r_ptr + 18'd1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_height  <= img_height;
                  r_row_len <= 18'(img_width) * 18'(cin_groups);
                  r_ptr     <= '0;
                  r_row     <= '0;
                  r_in_done <= 1'b0;
                  if (w_cfg_zero) begin
                     r_done <= 1'b1;
                  end else begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
                     r_state <= S_RUN;
`else
                     r_state <= S_FILL;
`endif
                  end
               end
            end
            S_FILL: begin
               if (w_accept && w_ptr_wrap) begin
                  if (w_last_row) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (r_row == 10'd1) begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
               if (w_accept && w_ptr_wrap && w_last_row) begin
                  r_state <= S_FLUSH;
               end
`else
               if (w_accept && w_ptr_wrap && w_last_row) begin
                  r_in_done <= 1'b1;
               end
               if (w_hs_last) begin
                  r_state <= S_IDLE;
               end
`endif
            end
            S_FLUSH: begin
               if (w_flush_step && w_ptr_wrap) begin
                  r_in_done <= 1'b1;
               end
               if (w_hs_last) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready = w_s_ready;
   assign m_tap0  = r_en0 ? r_rd_old : '0;
   assign m_tap1  = r_en1 ? r_rd_new : '0;
   assign m_tap2  = r_en2 ? r_data : '0;
   assign m_valid = r_valid;
   assign m_last  = r_last;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done || w_hs_last;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Randomized bench for line_buffer_3row: frames are checked against a row/column
// window model built directly from the input image held in queues.
module tb_line_buffer_3row;
   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  img_width;
   logic [9:0]  img_height;
   logic [7:0]  cin_groups;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] m_tap0;
   logic [63:0] m_tap1;
   logic [63:0] m_tap2;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        done;

   int n_checks;
   int n_pass;

   line_buffer_3row #(.WIDTH(64), .MAX_DEPTH(4096)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .img_width  (img_width),
      .img_height (img_height),
      .cin_groups (cin_groups),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_tap0     (m_tap0),
      .m_tap1     (m_tap1),
      .m_tap2     (m_tap2),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // abort_at >= 0: assert reset once that many words have been accepted.
   task automatic run_frame(input int w, input int h, input int g, input bit pat,
                            input int rdy_pct, input int abort_at);
      logic [63:0] in_q[$];
      logic [63:0] e0[$];
      logic [63:0] e1[$];
      logic [63:0] e2[$];
      bit          el[$];
      logic [63:0] p0, p1, p2;
      int          L, n_in, n_out, n_done, cyc, budget;
      bit          stalled, zero_cfg;

      L        = w * g;
      zero_cfg = (w == 0) || (h == 0) || (g == 0);
      if (!zero_cfg) begin
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
               for (int k = 0; k < g; k++)
                  in_q.push_back(pat ? {32'(r), 16'(c), 16'(k)} : {$urandom, $urandom});
`ifdef LINE_BUFFER_ZERO_PAD_EN
         for (int r = 0; r <= h; r++)
            for (int k = 0; k < L; k++) begin
               e0.push_back((r >= 2) ? in_q[(r-2)*L + k] : 64'd0);
               e1.push_back((r >= 1) ? in_q[(r-1)*L + k] : 64'd0);
               e2.push_back((r < h)  ? in_q[r*L + k]     : 64'd0);
               el.push_back((r == h) && (k == L-1));
            end
`else
         for (int r = 2; r < h; r++)
            for (int k = 0; k < L; k++) begin
               e0.push_back(in_q[(r-2)*L + k]);
               e1.push_back(in_q[(r-1)*L + k]);
               e2.push_back(in_q[r*L + k]);
               el.push_back((r == h-1) && (k == L-1));
            end
`endif
      end

      @(negedge clk);
      img_width  = 10'(w);
      img_height = 10'(h);
      cin_groups = 8'(g);
      start      = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      n_in    = 0;
      n_out   = 0;
      n_done  = 0;
      cyc     = 0;
      stalled = 1'b0;
      p0 = '0; p1 = '0; p2 = '0;
      budget  = 40 * (in_q.size() + e0.size()) + 50;

      while (n_done == 0 && cyc < budget) begin
         if (abort_at >= 0 && n_in == abort_at) begin
            s_valid = 1'b0;
            m_ready = 1'b0;
            rst     = 1'b1;
            #1;
            check_val("rst_m_valid", 64'(m_valid), 64'd0);
            check_val("rst_s_ready", 64'(s_ready), 64'd0);
            check_val("rst_busy",    64'(busy),    64'd0);
            check_val("rst_done",    64'(done),    64'd0);
            @(negedge clk);
            rst = 1'b0;
            $display("frame W=%0d H=%0d G=%0d aborted by reset after %0d accepts, %0d outputs",
                     w, h, g, n_in, n_out);
            return;
         end
         s_valid = (n_in < in_q.size()) && ($urandom_range(99) < 85);
         s_data  = (n_in < in_q.size()) ? in_q[n_in] : 64'd0;
         m_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (stalled) begin
            check_val("stall_valid", 64'(m_valid), 64'd1);
            check_val("stall_tap0", m_tap0, p0);
            check_val("stall_tap1", m_tap1, p1);
            check_val("stall_tap2", m_tap2, p2);
         end
         if (m_valid && m_ready) begin
            if (n_out < e0.size()) begin
               check_val("tap0", m_tap0, e0[n_out]);
               check_val("tap1", m_tap1, e1[n_out]);
               check_val("tap2", m_tap2, e2[n_out]);
               check_val("last", 64'(m_last), 64'(el[n_out]));
            end else begin
               check_val("extra_output", 64'(n_out), 64'(e0.size()));
            end
            n_out++;
         end
         if (done) begin
            n_done++;
            if (e0.size() > 0) begin
               check_val("done_at_last_hs", 64'(m_valid && m_ready && m_last), 64'd1);
               check_val("done_out_count", 64'(n_out), 64'(e0.size()));
            end else begin
               check_val("done_after_last_accept", 64'(n_in), 64'(in_q.size()));
            end
         end
         if (s_valid && s_ready) n_in++;
         stalled = m_valid && !m_ready;
         p0 = m_tap0; p1 = m_tap1; p2 = m_tap2;
         cyc++;
         @(negedge clk);
      end
      check_val("frame_done_in_budget", 64'(n_done), 64'd1);

      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (6) begin
         #1;
         if (m_valid) n_out++;
         if (done) n_done++;
         if (s_ready) n_in++;
         @(negedge clk);
      end
      check_val("out_count",  64'(n_out),  64'(e0.size()));
      check_val("done_count", 64'(n_done), 64'd1);
      check_val("in_count",   64'(n_in),   64'(in_q.size()));
      check_val("idle_busy",  64'(busy),   64'd0);
      $display("frame W=%0d H=%0d G=%0d inputs=%0d outputs=%0d/%0d done=%0d",
               w, h, g, n_in, n_out, e0.size(), n_done);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      start      = 1'b0;
      img_width  = '0;
      img_height = '0;
      cin_groups = '0;
      s_data     = '0;
      s_valid    = 1'b0;
      m_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_m_valid", 64'(m_valid), 64'd0);
      check_val("reset_s_ready", 64'(s_ready), 64'd0);
      check_val("reset_busy",    64'(busy),    64'd0);
      check_val("reset_done",    64'(done),    64'd0);
      check_val("reset_m_last",  64'(m_last),  64'd0);
      check_val("reset_tap0",    m_tap0,       64'd0);
      check_val("reset_tap1",    m_tap1,       64'd0);
      check_val("reset_tap2",    m_tap2,       64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_reset_busy", 64'(busy), 64'd0);

      run_frame(4, 4, 2, 1'b1, 100, -1);
      run_frame(4, 4, 2, 1'b1, 50, -1);
      run_frame(1, 2, 1, 1'b0, 50, -1);
      run_frame(416, 3, 1, 1'b0, 70, -1);
      run_frame(4, 4, 2, 1'b0, 100, 19);
      run_frame(4, 4, 2, 1'b0, 50, -1);
      run_frame(0, 4, 2, 1'b0, 50, -1);
      run_frame(2, 3, 1, 1'b0, 60, -1);
      for (int i = 0; i < 6; i++)
         run_frame($urandom_range(6, 1), $urandom_range(5, 1), $urandom_range(3, 1),
                   1'b0, $urandom_range(90, 30), -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
